// File: rtl/qec_syndrome_extractor.sv
// ---------------------------------------------------------------------------
// qec_syndrome_extractor
//
// Upstream stage of the Steane decoder. On a measure_start request it runs
// NUM_ROUNDS stabilizer readout rounds against the readout front-end. It
// majority-votes each of the 6 stabilizer bits and then presents a stable
// syndrome to the QEC feedback controller, together with a one-cycle
// measure_done pulse.
//
// Parameters
//   NUM_ROUNDS      readout rounds per measurement (odd, 1..7)
//   TIMEOUT_CYCLES  max cycles waiting for meas_valid in one round (1..65535)
//
// Ports
//   clk                in   system clock
//   rst_n              in   synchronous active-low reset
//   measure_start      in   level request from the controller
//   measure_done       out  one-cycle pulse, syndrome_x/z valid
//   syndrome_x[2:0]    out  voted X-stabilizer bits (decoder address [5:3])
//   syndrome_z[2:0]    out  voted Z-stabilizer bits (decoder address [2:0])
//   meas_timeout       out  set with measure_done if a round timed out
//   meas_req           out  one-cycle pulse requesting one readout round
//   meas_valid         in   readout result valid (one cycle per round)
//   meas_bits[5:0]     in   raw round result, [5:3]=X, [2:0]=Z
//   syndrome_unstable  out  per-bit round disagreement flags
//
// Optional feature macro: QEC_SYNDROME_UNSTABLE_EN
//   defined   -> syndrome_unstable is registered in VOTE
//   undefined -> syndrome_unstable is tied to zero
// ---------------------------------------------------------------------------
module qec_syndrome_extractor #(
  parameter int NUM_ROUNDS     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       measure_start,
  output logic       measure_done,
  output logic [2:0] syndrome_x,
  output logic [2:0] syndrome_z,
  output logic       meas_timeout,
  output logic       meas_req,
  input  logic       meas_valid,
  input  logic [5:0] meas_bits,
  output logic [5:0] syndrome_unstable
);

  localparam int CW = $clog2(NUM_ROUNDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] ROUNDS_C = CW'(NUM_ROUNDS);
  localparam logic [CW-1:0] HALF_C   = CW'(NUM_ROUNDS / 2);
  localparam logic [TW-1:0] TO_MAX_C = TW'(TIMEOUT_CYCLES);
  // Value of the timeout counter in the last allowed idle WAIT cycle.
  localparam logic [TW-1:0] TO_HIT_C = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_VOTE,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [CW-1:0] vote_cnt [6];
  logic [CW-1:0] round_cnt;
  logic [TW-1:0] to_cnt;
  logic          timed_out;

  logic          round_last;
  logic          timeout_hit;
  logic [5:0]    voted;

  // Accepting this round's result completes the measurement.
  assign round_last  = (round_cnt + CW'(1)) == ROUNDS_C;
  // meas_valid wins over a timeout that would fire in the same cycle.
  assign timeout_hit = !meas_valid && (to_cnt == TO_HIT_C);

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      voted[i] = vote_cnt[i] > HALF_C;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (measure_start) state_next = S_REQUEST;
      S_REQUEST: state_next = S_WAIT;
      S_WAIT: begin
        if (meas_valid) begin
          state_next = round_last ? S_VOTE : S_REQUEST;
        end else if (timeout_hit) begin
          state_next = S_VOTE;
        end
      end
      S_VOTE:    state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state only
  // ---------------------------------------------------------------------------
  always_comb begin
    meas_req     = 1'b0;
    measure_done = 1'b0;
    unique case (state)
      S_REQUEST: meas_req     = 1'b1;
      S_DONE:    measure_done = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: vote/round/timeout counters and registered results
  // ---------------------------------------------------------------------------
  // NOTE: the vote counter array is reset element by element; it is a
  // handful of flops rather than a RAM, and the spec requires it to be
  // cleared on reset so an aborted measurement leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) vote_cnt[i] <= '0;
      round_cnt    <= '0;
      to_cnt       <= '0;
      timed_out    <= 1'b0;
      meas_timeout <= 1'b0;
      syndrome_x   <= '0;
      syndrome_z   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (measure_start) begin
            for (int i = 0; i < 6; i++) vote_cnt[i] <= '0;
            round_cnt    <= '0;
            to_cnt       <= '0;
            timed_out    <= 1'b0;
            meas_timeout <= 1'b0;
          end
        end
        S_REQUEST: to_cnt <= '0;
        S_WAIT: begin
          if (meas_valid) begin
            for (int i = 0; i < 6; i++) begin
              vote_cnt[i] <= vote_cnt[i] + CW'(meas_bits[i]);
            end
            round_cnt <= round_cnt + CW'(1);
          end else if (timeout_hit) begin
            // Abandon the remaining rounds; zeroed counters vote 000/000.
            for (int i = 0; i < 6; i++) vote_cnt[i] <= '0;
            round_cnt <= '0;
            to_cnt    <= '0;
            timed_out <= 1'b1;
          end else if (to_cnt != TO_MAX_C) begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_VOTE: begin
          // Results only move here, so the decoder may sample them late.
          syndrome_x   <= voted[5:3];
          syndrome_z   <= voted[2:0];
          meas_timeout <= timed_out;
        end
        default: ;
      endcase
    end
  end

`ifdef QEC_SYNDROME_UNSTABLE_EN
  logic [5:0] unstable_q;

  // A bit is unstable when the rounds did not all agree on it. After a
  // timeout the counters are zero, so the flags come out as zero too.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      unstable_q <= '0;
    end else if (state == S_VOTE) begin
      for (int i = 0; i < 6; i++) begin
        unstable_q[i] <= (vote_cnt[i] != '0) && (vote_cnt[i] != ROUNDS_C);
      end
    end
  end

  assign syndrome_unstable = unstable_q;
`else
  assign syndrome_unstable = 6'b0;
`endif

endmodule
